// File: rtl/median_seq_ctrl.sv
// median_seq_ctrl: sequences a shift/compare-swap median datapath.
// A window of N_PIXELS pixels is shifted in (bypass mode). The datapath then
// runs (N_PIXELS+1)/2 compare/swap passes; each pass is one cycle shorter than
// the previous one and ends with a single bypass cycle. After the last pass,
// MED_DO holds the median. It is captured into DO and presented with DSO until
// downstream takes it.
// N_PIXELS must be odd and at least 3.
module median_seq_ctrl #(
   parameter int WIDTH    = 8,
   parameter int N_PIXELS = 9
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] DI,
   output logic [WIDTH-1:0] MED_DI,
   output logic             MED_EN,
   output logic             MED_BYP,
   output logic             MED_DSI,
   input  logic [WIDTH-1:0] MED_DO,
   output logic [WIDTH-1:0] DO,
   output logic             DSO,
   input  logic             OUT_READY
);

   localparam int CW     = $clog2(N_PIXELS + 1);
   localparam int PASSES = (N_PIXELS + 1) / 2;

   localparam logic [CW-1:0] LAST_PIX  = CW'(N_PIXELS - 1);
   localparam logic [CW-1:0] LAST_PASS = CW'(PASSES - 1);
   localparam logic [CW-1:0] N_CW      = CW'(N_PIXELS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SORT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    pix_q;       // pixels accepted so far in this window
   logic [CW-1:0]    pass_q;      // current sort pass
   logic [CW-1:0]    cyc_q;       // cycle within the current pass
   logic             in_ready_q;
   logic             byp_q;       // current SORT cycle is the last cycle of its pass
   logic             dso_q;
   logic [WIDTH-1:0] do_q;

   logic             accept_s;
   logic             in_sort_s;
   logic             pre_last_s;
   logic [CW-1:0]    pix_d;
   logic [CW-1:0]    pass_d;
   logic [CW-1:0]    cyc_d;

   // Handshake decode and counter increments shared by the state register.
   always_comb begin
      accept_s  = in_ready_q & IN_VALID;
      in_sort_s = (state_q == SORT);
      pix_d     = pix_q + CW'(1);
      pass_d    = pass_q + CW'(1);
      cyc_d     = cyc_q + CW'(1);
      // The next cycle is the final (bypass) cycle of pass p when c == N-p-2.
      pre_last_s = ((cyc_q + pass_q + CW'(2)) == N_CW);
   end

   // The pixel accepted in IDLE is pixel 1 and shifts into the datapath like
   // every other load pixel, so the strobes follow the accept handshake.
   assign MED_DI   = DI;
   assign IN_READY = in_ready_q;
   assign MED_EN   = accept_s | in_sort_s;
   assign MED_BYP  = accept_s | (in_sort_s & byp_q);
   assign MED_DSI  = accept_s;
   assign DO       = do_q;
   assign DSO      = dso_q;

   // Sequencer FSM with its counters and registered outputs; reset wins over all.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q    <= IDLE;
         pix_q      <= '0;
         pass_q     <= '0;
         cyc_q      <= '0;
         in_ready_q <= 1'b1;
         byp_q      <= 1'b0;
         dso_q      <= 1'b0;
         do_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (IN_VALID) begin
                  pix_q   <= CW'(1);
                  state_q <= LOAD;
               end else begin
                  pix_q   <= '0;
               end
            end
            LOAD: begin
               if (IN_VALID) begin
                  if (pix_q == LAST_PIX) begin
                     // Last pixel of the window: start pass 0 next cycle.
                     state_q    <= SORT;
                     in_ready_q <= 1'b0;
                     pix_q      <= '0;
                     pass_q     <= '0;
                     cyc_q      <= '0;
                     byp_q      <= 1'b0;
                  end else begin
                     pix_q      <= pix_d;
                  end
               end
            end
            SORT: begin
               if (byp_q) begin
                  if (pass_q == LAST_PASS) begin
                     // MED_DO now holds the median of the window.
                     state_q <= DONE;
                     do_q    <= MED_DO;
                     dso_q   <= 1'b1;
                     byp_q   <= 1'b0;
                  end else begin
                     // Every pass is at least two cycles long, so c=0 never bypasses.
                     pass_q  <= pass_d;
                     cyc_q   <= '0;
                     byp_q   <= 1'b0;
                  end
               end else begin
                  cyc_q <= cyc_d;
                  byp_q <= pre_last_s;
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  state_q    <= IDLE;
                  dso_q      <= 1'b0;
                  in_ready_q <= 1'b1;
                  pass_q     <= '0;
                  cyc_q      <= '0;
               end
            end
            default: begin
               state_q    <= IDLE;
               pix_q      <= '0;
               pass_q     <= '0;
               cyc_q      <= '0;
               in_ready_q <= 1'b1;
               byp_q      <= 1'b0;
               dso_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Self-checking bench for median_seq_ctrl (N_PIXELS=9 and N_PIXELS=3 instances).
// The compare/swap datapath is replaced by a behavioural model that records
// the pixels strobed in with MED_EN/MED_DSI and presents their median on MED_DO.
module tb_median_seq_ctrl;

   logic       CLK = 1'b0;
   logic       nrst;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] di;

   logic       rdy9, en9, byp9, dsi9, dso9;
   logic [7:0] mdi9, mdo9, do9;
   logic       rdy3, en3, byp3, dsi3, dso3;
   logic [7:0] mdi3, mdo3, do3;

   logic [7:0] win9 [9];
   logic [7:0] win3 [9];

   bit         sel3 = 1'b0;
   logic       v_rdy, v_en, v_byp, v_dsi, v_dso;
   logic [7:0] v_mdi, v_do;

   int         n_vec = 0;
   int         n_err = 0;

   always #5 CLK = ~CLK;

   median_seq_ctrl #(.WIDTH(8), .N_PIXELS(9)) dut9 (
      .CLK(CLK), .nRST(nrst), .IN_VALID(in_valid), .IN_READY(rdy9), .DI(di),
      .MED_DI(mdi9), .MED_EN(en9), .MED_BYP(byp9), .MED_DSI(dsi9), .MED_DO(mdo9),
      .DO(do9), .DSO(dso9), .OUT_READY(out_ready)
   );

   median_seq_ctrl #(.WIDTH(8), .N_PIXELS(3)) dut3 (
      .CLK(CLK), .nRST(nrst), .IN_VALID(in_valid), .IN_READY(rdy3), .DI(di),
      .MED_DI(mdi3), .MED_EN(en3), .MED_BYP(byp3), .MED_DSI(dsi3), .MED_DO(mdo3),
      .DO(do3), .DSO(dso3), .OUT_READY(out_ready)
   );

   // Median of the first n entries: sort a copy and take the middle element.
   function automatic logic [7:0] med(input logic [7:0] a [9], input int n);
      logic [7:0] s [9];
      logic [7:0] tmp;
      s = a;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n - 1 - i; j++) begin
            if (s[j] > s[j+1]) begin
               tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
            end
         end
      end
      return s[n/2];
   endfunction

   // Datapath model for the 9-pixel instance: keep the last 9 strobed pixels.
   always_ff @(posedge CLK) begin
      if (en9 && dsi9) begin
         for (int i = 0; i < 8; i++) win9[i] <= win9[i+1];
         win9[8] <= mdi9;
      end
   end

   // Datapath model for the 3-pixel instance: keep the last 3 strobed pixels.
   always_ff @(posedge CLK) begin
      if (en3 && dsi3) begin
         for (int i = 0; i < 2; i++) win3[i] <= win3[i+1];
         win3[2] <= mdi3;
      end
   end

   always_comb mdo9 = med(win9, 9);
   always_comb mdo3 = med(win3, 3);

   assign v_rdy = sel3 ? rdy3 : rdy9;
   assign v_en  = sel3 ? en3  : en9;
   assign v_byp = sel3 ? byp3 : byp9;
   assign v_dsi = sel3 ? dsi3 : dsi9;
   assign v_dso = sel3 ? dso3 : dso9;
   assign v_mdi = sel3 ? mdi3 : mdi9;
   assign v_do  = sel3 ? do3  : do9;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One window: load (with optional gaps), sort, done with backpressure,
   // return to IDLE. abort_at >= 0 pulls reset at that SORT cycle instead.
   task automatic run_window(input bit n3, input logic [7:0] px [9], input int gap_at,
                             input int gap_len, input bit rnd, input int bp,
                             input int abort_at);
      int         n, np, idx, gaps, t, lat;
      logic [7:0] m;
      bit         v;
      bit         q [$];
      n    = n3 ? 3 : 9;
      np   = (n + 1) / 2;
      sel3 = n3;
      m    = med(px, n);
      lat  = n;
      for (int p = 0; p < np; p++) begin
         lat += n - p;
         for (int z = 0; z < n - p - 1; z++) q.push_back(1'b0);
         q.push_back(1'b1);
      end
      idx = 0; gaps = 0; t = 0;
      while (idx < n) begin
         @(negedge CLK);
         v = 1'b1;
         if (idx > 0 && idx == gap_at && gaps < gap_len) v = 1'b0;
         if (rnd && idx > 0 && $urandom_range(0, 2) == 0) v = 1'b0;
         nrst      = 1'b1;
         in_valid  = v;
         di        = v ? px[idx] : 8'($urandom);
         out_ready = 1'($urandom);
         #1;
         chk("load_en", 64'({v_rdy, v_en, v_dso}), 64'({1'b1, v, 1'b0}));
         if (v) chk("load_px", 64'({v_byp, v_dsi, v_mdi}), 64'({2'b11, px[idx]}));
         if (v) idx++; else gaps++;
         t++;
      end
      for (int k = 0; k < q.size(); k++) begin
         @(negedge CLK);
         in_valid  = rnd ? 1'($urandom) : 1'b1;
         di        = 8'($urandom);
         out_ready = 1'($urandom);
         nrst      = (k == abort_at) ? 1'b0 : 1'b1;
         #1;
         chk("sort", 64'({v_rdy, v_en, v_byp, v_dsi, v_dso}), 64'({1'b0, 1'b1, q[k], 1'b0, 1'b0}));
         t++;
         if (k == abort_at) begin
            @(negedge CLK);
            nrst     = 1'b1;
            in_valid = 1'b0;
            #1;
            chk("post_reset", 64'({v_rdy, v_en, v_byp, v_dsi, v_dso, v_do}), 64'({5'b10000, 8'h00}));
            return;
         end
      end
      for (int i = 0; i <= bp; i++) begin
         @(negedge CLK);
         in_valid  = rnd ? 1'($urandom) : 1'b1;
         di        = 8'($urandom);
         out_ready = (i == bp);
         #1;
         chk("done", 64'({v_rdy, v_en, v_byp, v_dsi, v_dso, v_do}), 64'({5'b00001, m}));
         if (i == 0) chk("latency", 64'(t), 64'(lat + gaps));
         t++;
      end
      @(negedge CLK);
      in_valid  = 1'b0;
      out_ready = 1'($urandom);
      #1;
      chk("idle_after", 64'({v_rdy, v_en, v_byp, v_dsi, v_dso}), 64'(5'b10000));
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      nrst     = 1'b0;
      in_valid = 1'b0;
      @(negedge CLK);
      nrst     = 1'b1;
   endtask

   typedef struct {
      logic        nrst;
      logic        vld;
      logic [7:0]  di;
      logic [12:0] mask;   // {rdy, en, byp, dsi, dso, do[7:0]}
      logic [12:0] exp;
   } vec_t;

   initial begin
      vec_t       tbl [8];
      logic [7:0] px [9];

      // IDLE, accept pixel 1, stall, reset mid-load, restart, reset in stall.
      tbl[0] = '{1'b1, 1'b0, 8'h00, 13'h1FFF, 13'h1000};
      tbl[1] = '{1'b1, 1'b1, 8'hA5, 13'h1FFF, 13'h1E00};
      tbl[2] = '{1'b1, 1'b0, 8'h00, 13'h19FF, 13'h1000};
      tbl[3] = '{1'b0, 1'b1, 8'h3C, 13'h1FFF, 13'h1E00};
      tbl[4] = '{1'b1, 1'b0, 8'h00, 13'h1FFF, 13'h1000};
      tbl[5] = '{1'b1, 1'b1, 8'h11, 13'h1FFF, 13'h1E00};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 13'h19FF, 13'h1000};
      tbl[7] = '{1'b1, 1'b0, 8'h00, 13'h1FFF, 13'h1000};

      nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; di = 8'h00;
      repeat (2) @(posedge CLK);

      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         nrst      = tbl[i].nrst;
         in_valid  = tbl[i].vld;
         di        = tbl[i].di;
         out_ready = 1'b0;
         #1;
         chk($sformatf("vec%0d", i),
             64'({v_rdy, v_en, v_byp, v_dsi, v_dso, v_do} & tbl[i].mask),
             64'(tbl[i].exp & tbl[i].mask));
         if (tbl[i].vld) chk($sformatf("vec%0d_di", i), 64'(v_mdi), 64'(tbl[i].di));
      end

      px = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
      run_window(1'b0, px, -1, 0, 1'b0, 0, -1);   // streaming
      run_window(1'b0, px, 4, 3, 1'b0, 0, -1);    // stall after pixel 4
      run_window(1'b0, px, -1, 0, 1'b0, 10, -1);  // backpressure
      run_window(1'b0, px, -1, 0, 1'b0, 0, 19);   // reset in pass 2
      px = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      run_window(1'b0, px, -1, 0, 1'b0, 0, -1);

      for (int w = 0; w < 6; w++) begin
         for (int k = 0; k < 9; k++) px[k] = 8'($urandom);
         run_window(1'b0, px, -1, 0, 1'b1, int'($urandom_range(0, 3)), -1);
      end

      pulse_reset();
      px = '{8'd30, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      run_window(1'b1, px, -1, 0, 1'b0, 0, -1);
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 9; k++) px[k] = 8'($urandom);
         run_window(1'b1, px, -1, 0, 1'b1, int'($urandom_range(0, 3)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/median_seq_ctrl.md
MEDIAN_SEQ_CTRL -- requirements
Module: median_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter N_PIXELS, default 9, meaning window size; it must be odd and at least 3.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port nRST, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port IN_VALID, input, 1 bit: upstream pixel on DI is valid.
REQ-006 The block SHALL have port IN_READY, output, 1 bit: the block accepts DI this cycle.
REQ-007 The block SHALL have port DI, input, WIDTH bits: upstream pixel.
REQ-008 The block SHALL have port MED_DI, output, WIDTH bits: pixel to the compare/swap datapath; combinationally equal to DI.
REQ-009 The block SHALL have port MED_EN, output, 1 bit: datapath register enable.
REQ-010 The block SHALL have port MED_BYP, output, 1 bit: datapath bypass; 1 means shift through, 0 means compare/swap.
REQ-011 The block SHALL have port MED_DSI, output, 1 bit: datapath load strobe.
REQ-012 The block SHALL have port MED_DO, input, WIDTH bits: datapath output register.
REQ-013 The block SHALL have port DO, output, WIDTH bits: registered median result.
REQ-014 The block SHALL have port DSO, output, 1 bit: DO holds a valid median.
REQ-015 The block SHALL have port OUT_READY, input, 1 bit: downstream consumes DO when DSO and OUT_READY are both 1.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SORT and DONE, and SHALL be encoded in a single state register.
REQ-017 In IDLE, the block SHALL assert IN_READY and SHALL move to LOAD on the first accepted pixel (IN_VALID and IN_READY both 1), counting that pixel as pixel 1.
REQ-018 In LOAD, the block SHALL hold IN_READY at 1 and SHALL accept N_PIXELS pixels in total; an idle IN_VALID cycle SHALL stall the load with MED_EN=0 and SHALL not count.
REQ-019 For every accepted LOAD pixel, the block SHALL drive MED_EN=1, MED_BYP=1 and MED_DSI=1.
REQ-020 After pixel N_PIXELS is accepted, the block SHALL move to SORT on the next cycle with pass counter p=0 and cycle counter c=0.
REQ-021 The number of SORT passes SHALL be P=(N_PIXELS+1)/2, which is 5 for the default.
REQ-022 Pass p SHALL last N_PIXELS-p cycles: cycles c=0..N_PIXELS-p-2 with MED_BYP=0, and the last cycle with MED_BYP=1.
REQ-023 Throughout SORT, the block SHALL drive MED_EN=1, MED_DSI=0 and IN_READY=0.
REQ-024 At the end of pass P-1, the block SHALL register MED_DO into DO on the same edge, enter DONE and set DSO=1.
REQ-025 In DONE, DSO and DO SHALL stay stable until OUT_READY=1; in that cycle the block SHALL return to IDLE, with DSO=0 from the next cycle.
REQ-026 Outside LOAD and SORT, the block SHALL drive MED_EN=0, MED_BYP=0 and MED_DSI=0.
REQ-027 Latency without stalls SHALL be: DSO rises exactly N_PIXELS + sum over p=0..P-1 of (N_PIXELS-p) cycles after pixel 1 is accepted; this is 9+35=44 cycles for the default.
REQ-028 IN_READY SHALL be 0 in SORT and DONE; DI SHALL be ignored there, with no buffering and no data loss counted.
REQ-029 Counter widths SHALL be $clog2(N_PIXELS+1) bits; counters SHALL never wrap within a window; the pass counter SHALL clear to 0 on every entry to SORT.
REQ-030 A new window SHALL start only from IDLE; back-to-back windows SHALL have at least one IDLE cycle between them.
REQ-031 A held OUT_READY=1 during DONE SHALL complete the handshake in the first DONE cycle.

Reset
REQ-032 When nRST=0 at a clock edge, the block SHALL enter IDLE and clear all counters; mid-window contents SHALL be discarded.
REQ-033 Reset values SHALL be: DO=0, DSO=0, IN_READY=1 (IDLE), MED_EN=0, MED_BYP=0, MED_DSI=0.
REQ-034 A reset asserted in any state SHALL take precedence over every other transition in that same cycle.

Verification
REQ-035 Streaming test: pixels 9,1,8,2,7,3,6,4,5 with IN_VALID held high and OUT_READY=1, against a behavioral MED model -> DSO high for exactly one cycle 44 cycles after pixel 1, with DO=5.
REQ-036 Stall test: the same data with IN_VALID low for 3 cycles after pixel 4 -> MED_EN=0 during the gaps, DSO at cycle 47, DO=5.
REQ-037 Backpressure test: OUT_READY=0 for 10 cycles in DONE -> DSO and DO stable at 5 throughout, IN_READY=0; return to IDLE the cycle after OUT_READY=1.
REQ-038 Reset test: nRST=0 during SORT pass 2 -> the next cycle shows IDLE and reset values; a new window 1..9 then yields DO=5.
REQ-039 Bypass-pattern test: trace MED_BYP in SORT -> runs of 0s of lengths 8,7,6,5,4, each followed by a single 1.
REQ-040 Parameter test: N_PIXELS=3 with pixels 30,10,20 -> P=2, DSO 3+3+2=8 cycles after pixel 1, DO=20.
